irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Parametrised successor to the core's fixed hardware/software interrupt arbitration and PC-redirect logic.
- Latches NUM_SRC hardware lines plus one software trap, masks and prioritises them, and nests up to DEPTH levels on an internal return stack.
- Drives a one-cycle PC redirect that the PC adder muxes over the normal next PC.
- Sits between the instruction decoder (software trap, eret), external devices and the PC adder.

Parameters:
NUM_SRC, 8, number of hardware interrupt lines (1..16)
PC_W, 16, PC and vector width
DEPTH, 4, maximum nesting depth of the return stack (1..8)
VEC_BASE, 16'h0010, handler address of index 0
VEC_STRIDE, 4, address distance between consecutive vectors

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
irq_in  in  NUM_SRC  hardware lines, asynchronous; rising edge requests
sw_int  in  1  software trap from decoder, one-cycle pulse
sw_index  in  4  software trap index
eret  in  1  return from interrupt, one-cycle pulse
normal_next_pc  in  PC_W  PC that would execute next without redirect
mask_we  in  1  write mask register
mask_wdata  in  NUM_SRC  new mask value (1 = enabled)
redirect  out  1  one-cycle pulse: PC must take redirect_pc
redirect_pc  out  PC_W  handler vector or return PC
cause  out  5  {is_sw, index} of innermost in-service interrupt
pending  out  NUM_SRC  latched hardware requests
mask  out  NUM_SRC  current mask
depth  out  4  current nesting level
overflow  out  1  sticky: software trap lost because stack was full

Behaviour:
- Reset: pending=0, mask=all ones, depth=0, redirect=0, redirect_pc=0, cause=0, overflow=0, stack cleared, synchronisers cleared; asynchronous, takes effect mid-redirect.
- irq_in goes through a 2-flop synchroniser, then a rising-edge detector. An edge sets pending[i]. Pending bits are independent of mask; a masked bit stays pending until unmasked.
- Mask write takes effect the next cycle.
- Priority, evaluated each cycle:
  - A software trap beats all hardware requests.
  - Among hardware requests, the lowest index of (pending & mask) wins.
  - A hardware request is taken only if depth==0, or its index is strictly lower than the in-service hardware index. Lower index means higher priority.
  - While a software trap is in service, hardware requests are blocked.
  - Software traps are always accepted if stack space remains.
- Take, registered, 1-cycle latency:
  - push {normal_next_pc, is_sw, index}.
  - depth+1.
  - Clear the taken pending bit; an edge arriving in the same cycle re-sets it.
  - redirect=1 for one cycle.
  - redirect_pc = VEC_BASE + index*VEC_STRIDE. Software vectors use index+NUM_SRC. Arithmetic is truncated to PC_W.
- eret with depth>0: pop, depth-1, redirect=1, redirect_pc = saved PC. eret with depth==0 is ignored (no redirect).
- Same-cycle eret and request: eret wins. The request is re-evaluated the next cycle against the popped state. A software trap arriving in that cycle is held in a 1-entry software latch until it can be taken.
- Stack full (depth==DEPTH):
  - Hardware requests stay pending.
  - A software trap is dropped and sets overflow. overflow is cleared only by reset.
- redirect never asserts in two consecutive cycles. After any redirect, one cycle passes before the next take or return.
- FSM states:
  - IDLE: on take go to REDIR; on eret go to REDIR.
  - REDIR: outputs valid; go to SETTLE.
  - SETTLE: go to IDLE.

Test Plan:
- Reset, then rising edge on irq_in[3] with mask=FF -> 2 sync cycles plus 1, redirect=1 for one cycle, redirect_pc=16'h001C, depth=1, cause=0_0011, pending[3]=0.
- In service irq 3, then raise irq 1 and irq 5 together -> irq 1 nests (redirect_pc=16'h0014, depth=2); irq 5 stays pending; eret returns to saved PC; second eret returns; then irq 5 is taken.
- mask=FE, edge on irq_in[0] -> no redirect, pending[0]=1; write mask=FF -> redirect to 16'h0010 two cycles later.
- sw_int with sw_index=2 and NUM_SRC=8 at normal_next_pc=16'h0123 -> redirect_pc=16'h0038; eret -> redirect_pc=16'h0123.
- Fill stack to DEPTH=4, then sw_int -> no redirect, overflow=1, depth stays 4.
- eret and irq edge in the same cycle -> return redirect first; interrupt redirect no earlier than 2 cycles later. Assert rst mid-REDIR -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt arbiter with nested return stack: synchronises hardware lines, prioritises them
// against a software trap, and emits a one-cycle PC redirect for each take or return.
module irq_controller #(
  parameter int unsigned     NUM_SRC    = 8,
  parameter int unsigned     PC_W       = 16,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [PC_W-1:0] VEC_BASE   = 16'h0010,
  parameter int unsigned     VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               sw_int,
  input  logic [3:0]         sw_index,
  input  logic               eret,
  input  logic [PC_W-1:0]    normal_next_pc,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [4:0]         cause,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [3:0]         depth,
  output logic               overflow
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;

  typedef enum logic [1:0] {IDLE, REDIR, SETTLE} state_t;
  state_t state, state_n;

  logic [NUM_SRC-1:0] sync1, sync2, sync3, edges, req, clr;
  logic [PC_W-1:0]    stk_pc    [SLOTS];
  logic [4:0]         stk_cause [SLOTS];
  logic [PTR_W-1:0]   top_ptr, push_ptr;
  logic [4:0]         top_cause;
  logic               sw_hold, sw_req;
  logic [3:0]         sw_hold_idx, sw_idx;
  logic               hw_any, hw_ok;
  logic [3:0]         hw_idx, take_idx;
  logic               idle, full, do_ret, sw_take, sw_drop, hw_take;
  logic [PC_W-1:0]    take_vec;

  function automatic logic [PC_W-1:0] vec_addr(input logic is_sw, input logic [3:0] idx);
    logic [31:0] slot, off;
    slot = 32'(idx) + (is_sw ? 32'(NUM_SRC) : 32'd0);
    off  = slot * 32'(VEC_STRIDE);
    return VEC_BASE + off[PC_W-1:0];
  endfunction

  assign edges     = sync2 & ~sync3;
  assign req       = pending & mask;
  assign top_ptr   = PTR_W'(depth - 4'd1);
  assign push_ptr  = PTR_W'(depth);
  assign top_cause = stk_cause[top_ptr];
  assign cause     = (depth == '0) ? '0 : top_cause;
  assign redirect  = (state == REDIR);

  always_comb begin
    hw_any = 1'b0;
    hw_idx = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (req[i-1]) begin
        hw_any = 1'b1;
        hw_idx = 4'(i - 1);
      end
    end
  end

  // A held software trap outranks a fresh pulse so traps are served in arrival order.
  always_comb begin
    idle     = (state == IDLE);
    full     = (depth == 4'(DEPTH));
    sw_req   = sw_hold | sw_int;
    sw_idx   = sw_hold ? sw_hold_idx : sw_index;
    hw_ok    = (depth == '0) | (~top_cause[4] & (hw_idx < top_cause[3:0]));
    do_ret   = idle & eret & (depth != '0);
    sw_take  = idle & ~do_ret & sw_req & ~full;
    sw_drop  = idle & ~do_ret & sw_req & full;
    hw_take  = idle & ~do_ret & ~sw_req & hw_any & ~full & hw_ok;
    take_idx = sw_take ? sw_idx : hw_idx;
    take_vec = vec_addr(sw_take, take_idx);
    clr      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      clr[i] = hw_take & (hw_idx == 4'(i));
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (do_ret | sw_take | hw_take) state_n = REDIR;
      REDIR:   state_n = SETTLE;
      SETTLE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      sync3       <= '0;
      pending     <= '0;
      mask        <= '1;
      depth       <= '0;
      redirect_pc <= '0;
      overflow    <= 1'b0;
      sw_hold     <= 1'b0;
      sw_hold_idx <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        stk_pc[i]    <= '0;
        stk_cause[i] <= '0;
      end
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= (pending & ~clr) | edges;
      if (mask_we) mask <= mask_wdata;
      if (sw_drop) overflow <= 1'b1;
      if (sw_take | sw_drop) begin
        sw_hold <= 1'b0;
      end else if (sw_int & ~sw_hold) begin
        sw_hold     <= 1'b1;
        sw_hold_idx <= sw_index;
      end
      if (do_ret) begin
        depth       <= depth - 4'd1;
        redirect_pc <= stk_pc[top_ptr];
      end else if (sw_take | hw_take) begin
        stk_pc[push_ptr]    <= normal_next_pc;
        stk_cause[push_ptr] <= {sw_take, take_idx};
        depth               <= depth + 4'd1;
        redirect_pc         <= take_vec;
      end
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_irq_controller;
  localparam int NSRC    = 8;
  localparam int DEPTH_P = 4;
  localparam int VBASE   = 16;
  localparam int VSTRIDE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        sw_int;
  logic [3:0]  sw_index;
  logic        eret;
  logic [15:0] normal_next_pc;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [4:0]  cause;
  logic [7:0]  pending;
  logic [7:0]  mask;
  logic [3:0]  depth;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(
    .NUM_SRC(NSRC), .PC_W(16), .DEPTH(DEPTH_P), .VEC_BASE(16'h0010), .VEC_STRIDE(VSTRIDE)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sw_int(sw_int), .sw_index(sw_index),
    .eret(eret), .normal_next_pc(normal_next_pc), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .cause(cause), .pending(pending),
    .mask(mask), .depth(depth), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  irq;
    logic        sw;
    logic [3:0]  swi;
    logic        er;
    logic        mwe;
    logic [7:0]  mwd;
    logic [15:0] npc;
    logic        x_redir;
    logic [15:0] x_pc;
    logic [3:0]  x_depth;
    logic [4:0]  x_cause;
    logic [7:0]  x_pend;
    logic [7:0]  x_mask;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] irq, input logic sw, input logic [3:0] swi, input logic er,
                     input logic mwe, input logic [7:0] mwd, input logic [15:0] npc,
                     input logic r, input logic [15:0] pc, input logic [3:0] d,
                     input logic [4:0] c, input logic [7:0] p, input logic [7:0] m);
    vec_t v;
    v.irq = irq; v.sw = sw; v.swi = swi; v.er = er; v.mwe = mwe; v.mwd = mwd; v.npc = npc;
    v.x_redir = r; v.x_pc = pc; v.x_depth = d; v.x_cause = c; v.x_pend = p; v.x_mask = m;
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic [7:0] irq, input logic sw, input logic [3:0] swi,
                        input logic er, input logic [15:0] npc);
    irq_in = irq; sw_int = sw; sw_index = swi; eret = er; normal_next_pc = npc;
    mask_we = 1'b0; mask_wdata = '0;
  endtask

  // Reference model: stack as a queue of frames, lockout as a cycle countdown.
  typedef struct { logic [15:0] pc; bit is_sw; int idx; } frame_t;
  frame_t      m_stk[$];
  logic [7:0]  ms1, ms2, ms3, m_pend, m_mask;
  int          m_gap, m_swi;
  bit          m_redir, m_ovf, m_swv;
  logic [15:0] m_rpc;

  function automatic logic [15:0] vec(input bit sw, input int idx);
    return 16'(VBASE + (sw ? idx + NSRC : idx) * VSTRIDE);
  endfunction

  task automatic model_reset();
    m_stk.delete();
    ms1 = '0; ms2 = '0; ms3 = '0; m_pend = '0; m_mask = '1;
    m_gap = 0; m_swi = 0; m_redir = 0; m_ovf = 0; m_swv = 0; m_rpc = '0;
  endtask

  task automatic model_step();
    logic [7:0] edges, clr;
    bit act, sw_used;
    frame_t f;
    int win, idx;
    edges = ms2 & ~ms3; clr = '0; act = 0; sw_used = 0;
    if (m_gap == 0) begin
      if (eret && m_stk.size() > 0) begin
        f = m_stk.pop_back();
        m_rpc = f.pc; act = 1;
      end else if (m_swv || sw_int) begin
        idx = m_swv ? m_swi : int'(sw_index);
        m_swv = 0; sw_used = 1;
        if (m_stk.size() < DEPTH_P) begin
          f.pc = normal_next_pc; f.is_sw = 1; f.idx = idx;
          m_stk.push_back(f);
          m_rpc = vec(1, idx); act = 1;
        end else m_ovf = 1;
      end else begin
        win = -1;
        for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
        if (win >= 0 && m_stk.size() < DEPTH_P &&
            (m_stk.size() == 0 || (!m_stk[$].is_sw && win < m_stk[$].idx))) begin
          f.pc = normal_next_pc; f.is_sw = 0; f.idx = win;
          m_stk.push_back(f);
          clr = 8'd1 << win;
          m_rpc = vec(0, win); act = 1;
        end
      end
    end
    if (sw_int && !sw_used && !m_swv) begin
      m_swv = 1; m_swi = int'(sw_index);
    end
    m_redir = act;
    if (act) m_gap = 2;
    else if (m_gap > 0) m_gap--;
    m_pend = (m_pend & ~clr) | edges;
    if (mask_we) m_mask = mask_wdata;
    ms3 = ms2; ms2 = ms1; ms1 = irq_in;
  endtask

  initial begin
    int exp_cause;
    rst = 1'b1;
    set_in(8'h00, 0, 4'd0, 0, 16'h0000);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_redirect", redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_cause", cause, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mask", mask, 8'hFF);
    chk("rst_depth", depth, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    //   irq    sw swi er mwe mwd    npc       r  pc        d  cause  pend   mask
    add(8'h08, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h08, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h08, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h08, 8'hFF);
    add(8'h08, 0, 0, 0, 0, 8'h00, 16'h0200, 1, 16'h001C, 1, 5'h03, 8'h00, 8'hFF);
    add(8'h08, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h03, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h03, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h03, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h03, 8'h22, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0300, 1, 16'h0014, 2, 5'h01, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 2, 5'h01, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 2, 5'h01, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0300, 1, 5'h03, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h03, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h03, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0200, 0, 5'h00, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h20, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0400, 1, 16'h0024, 1, 5'h05, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h05, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h05, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0400, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h2A, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 1, 8'hFE, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFE);
    add(8'h01, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFE);
    add(8'h01, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFE);
    add(8'h01, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h01, 8'hFE);
    add(8'h01, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h01, 8'hFE);
    add(8'h01, 0, 0, 0, 1, 8'hFF, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h01, 8'hFF);
    add(8'h01, 0, 0, 0, 0, 8'h00, 16'h0500, 1, 16'h0010, 1, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0500, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 1, 2, 0, 0, 8'h00, 16'h0123, 1, 16'h0038, 1, 5'h12, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h12, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 5'h12, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0123, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);
    add(8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 5'h00, 8'h00, 8'hFF);

    foreach (tbl[k]) begin
      set_in(tbl[k].irq, tbl[k].sw, tbl[k].swi, tbl[k].er, tbl[k].npc);
      mask_we = tbl[k].mwe; mask_wdata = tbl[k].mwd;
      @(negedge clk);
      chk($sformatf("tbl%0d_redirect", k), redirect, tbl[k].x_redir);
      if (tbl[k].x_redir) chk($sformatf("tbl%0d_pc", k), redirect_pc, tbl[k].x_pc);
      chk($sformatf("tbl%0d_depth", k), depth, tbl[k].x_depth);
      chk($sformatf("tbl%0d_cause", k), cause, tbl[k].x_cause);
      chk($sformatf("tbl%0d_pending", k), pending, tbl[k].x_pend);
      chk($sformatf("tbl%0d_mask", k), mask, tbl[k].x_mask);
    end

    // Fill the stack with software traps, then one more must be dropped.
    for (int k = 0; k < 4; k++) begin
      set_in(8'h00, 1, 4'd1, 0, 16'h1000 + 16'(k));
      @(negedge clk);
      chk("fill_redirect", redirect, 1);
      chk("fill_depth", depth, k + 1);
      set_in(8'h00, 0, 4'd0, 0, 16'h0000);
      repeat (2) @(negedge clk);
    end
    set_in(8'h00, 1, 4'd3, 0, 16'h0BAD);
    @(negedge clk);
    chk("full_no_redirect", redirect, 0);
    chk("full_overflow", overflow, 1);
    chk("full_depth", depth, 4);
    chk("full_cause", cause, 5'h11);
    set_in(8'h00, 0, 4'd0, 0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("full_still_no_redirect", redirect, 0);
    for (int k = 3; k >= 0; k--) begin
      set_in(8'h00, 0, 4'd0, 1, 16'h0000);
      @(negedge clk);
      chk("unwind_redirect", redirect, 1);
      chk("unwind_pc", redirect_pc, 16'h1000 + 16'(k));
      chk("unwind_depth", depth, k);
      set_in(8'h00, 0, 4'd0, 0, 16'h0000);
      repeat (2) @(negedge clk);
    end
    chk("overflow_sticky", overflow, 1);

    // eret and a pending hardware request in the same cycle.
    set_in(8'h00, 1, 4'd0, 0, 16'h2222);
    @(negedge clk);
    chk("sw0_pc", redirect_pc, 16'h0030);
    set_in(8'h00, 0, 4'd0, 0, 16'h0000);
    repeat (2) @(negedge clk);
    irq_in = 8'h10;
    repeat (3) @(negedge clk);
    chk("blocked_pending", pending, 8'h10);
    chk("blocked_redirect", redirect, 0);
    set_in(8'h10, 0, 4'd0, 1, 16'h3333);
    @(negedge clk);
    chk("race_ret_redirect", redirect, 1);
    chk("race_ret_pc", redirect_pc, 16'h2222);
    chk("race_ret_depth", depth, 0);
    set_in(8'h10, 0, 4'd0, 0, 16'h4444);
    @(negedge clk);
    chk("race_gap1", redirect, 0);
    @(negedge clk);
    chk("race_gap2", redirect, 0);
    @(negedge clk);
    chk("race_take_redirect", redirect, 1);
    chk("race_take_pc", redirect_pc, 16'h0020);
    chk("race_take_cause", cause, 5'h04);
    chk("race_take_pending", pending, 0);

    // Asynchronous reset while the redirect pulse is high.
    #2 rst = 1'b1;
    #1;
    chk("arst_redirect", redirect, 0);
    chk("arst_pc", redirect_pc, 0);
    chk("arst_depth", depth, 0);
    chk("arst_cause", cause, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_mask", mask, 8'hFF);
    chk("arst_pending", pending, 0);
    set_in(8'h00, 0, 4'd0, 0, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'd1 << $urandom_range(0, 7));
      sw_int         = (!m_swv && $urandom_range(0, 11) == 0);
      sw_index       = 4'($urandom_range(0, 15));
      eret           = (m_gap == 0 && $urandom_range(0, 4) == 0);
      mask_we        = ($urandom_range(0, 19) == 0);
      mask_wdata     = 8'($urandom);
      normal_next_pc = 16'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_redirect", redirect, m_redir);
      if (m_redir) chk("rnd_pc", redirect_pc, m_rpc);
      chk("rnd_depth", depth, m_stk.size());
      exp_cause = (m_stk.size() == 0) ? 0 : ((m_stk[$].is_sw ? 16 : 0) + m_stk[$].idx);
      chk("rnd_cause", cause, exp_cause);
      chk("rnd_pending", pending, m_pend);
      chk("rnd_mask", mask, m_mask);
      chk("rnd_overflow", overflow, m_ovf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
